// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with done/withdraw/timeout release and registered outputs.
module rr_arbiter8 #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);
    typedef enum logic {IDLE, GRANT} state_t;
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
    state_t     state, state_n;
    logic [2:0] ptr, ptr_n, idx_n, sel, j;
    logic [7:0] cnt, cnt_n, grant_n;
    logic       valid_n, to_n, release_n;
    always_comb begin
        sel = ptr;
        j = ptr;
        for (int k = 7; k >= 0; k--) begin
            j = ptr + 3'(k);
            if (req[j]) sel = j;
        end
    end
    always_comb begin
        state_n = state;
        ptr_n = ptr;
        cnt_n = cnt;
        grant_n = grant;
        idx_n = gnt_idx;
        valid_n = gnt_valid;
        to_n = 1'b0;
        release_n = done || !req[gnt_idx] || cnt == LAST;
        if (state == IDLE) begin
            if (|req) begin
                state_n = GRANT;
                grant_n = 8'b1 << sel;
                idx_n = sel;
                valid_n = 1'b1;
                cnt_n = 8'd0;
            end
        end else if (release_n) begin
            state_n = IDLE;
            grant_n = 8'd0;
            idx_n = 3'd0;
            valid_n = 1'b0;
            ptr_n = gnt_idx + 3'd1;
            // only a pure timer expiry pulses timeout; done or withdrawal take precedence
            to_n = !done && req[gnt_idx];
        end else begin
            cnt_n = cnt + 8'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr <= 3'd0;
            cnt <= 8'd0;
            grant <= 8'd0;
            gnt_idx <= 3'd0;
            gnt_valid <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            cnt <= cnt_n;
            grant <= grant_n;
            gnt_idx <= idx_n;
            gnt_valid <= valid_n;
            timeout <= to_n;
        end
    end
endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares one 8-way resource slot among eight requesters. Each cycle in which the resource is free, it picks the next active request after the most recently served index, wrapping from 7 to 0. It then holds that grant until the owner signals completion, withdraws its request, or the hold timer expires. It drives a one-hot grant vector plus the 3-bit binary index of the owner, the same index format the 8-to-3 encoder produces, so downstream muxes select by index.

## Interface
Parameters:
- TIMEOUT, 16, maximum cycles a grant is held without `done`; legal range 2..256.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; bit i = requester i wants the resource.
- done  input  1  owner finished; sampled only while a grant is active.
- grant  output  8  one-hot grant; all zero when idle.
- gnt_idx  output  3  binary index of the granted bit; 0 when idle.
- gnt_valid  output  1  high while a grant is active; equals OR of `grant`.
- timeout  output  1  one-cycle pulse when a grant was revoked by the timer.

## Operation
- State: `IDLE`, `GRANT`; round-robin pointer `ptr[2:0]`; hold counter `cnt` of 8 bits, compared against TIMEOUT-1.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset: state `IDLE`, `ptr`=0, `cnt`=0, `grant`=0, `gnt_idx`=0, `gnt_valid`=0, `timeout`=0. Reset overrides everything, including in the middle of a grant.
- `IDLE` with `req`=0: stay in `IDLE`, outputs remain 0.
- `IDLE` with `req`≠0:
  - Select the first set bit scanning `ptr`, `ptr`+1, … modulo 8.
  - Load `grant` (one-hot) and `gnt_idx` with that bit.
  - Set `gnt_valid`=1 and `cnt`=0, and go to `GRANT`.
- `GRANT` release conditions, evaluated each cycle in this priority order:
  1. `done`=1: normal release, no `timeout` pulse.
  2. `req[gnt_idx]`=0: withdrawal, no `timeout` pulse.
  3. `cnt`==TIMEOUT-1: forced release; `timeout`=1 for the following cycle.
  4. Otherwise `cnt` increments by 1 and the grant is held.
- On any release:
  - Go to `IDLE`; `grant`, `gnt_idx` and `gnt_valid` clear.
  - Set `ptr` = `gnt_idx`+1 modulo 8, so 7 wraps to 0.
- `IDLE` after a release is a mandatory one-cycle gap: arbitration happens in that cycle, so the earliest next grant is one cycle later. Back-to-back grants therefore have exactly one idle cycle between them.
- The `timeout` pulse coincides with that gap cycle and is 0 at all other times.
- `req` bits other than the owner's are ignored while in `GRANT`. `done` is ignored in `IDLE`.
- `ptr` advances only on release, never on a request that goes unserved.

## Timing
- Request-to-grant latency: `req` sampled at edge E, `grant` visible after E (1 cycle).
- Grant duration:
  - `done` or withdrawal sampled at edge F releases the grant, and it is low after F.
  - Minimum grant is 1 cycle, when `done` is high in the first `GRANT` cycle.
  - Maximum grant is exactly TIMEOUT cycles.
- Release-to-next-grant: 2 edges (gap cycle plus the arbitration register).
- Simultaneous `done` and timer expiry: `done` wins, so `timeout` stays 0.
- `rst` asserted at edge R: all outputs are 0 after R, and the first grant after reset uses `ptr`=0.

## Test plan
- Idle: after reset, `req`=8'h00 for 10 cycles -> `grant`=0, `gnt_idx`=0, `gnt_valid`=0, `timeout`=0 throughout.
- Basic rotation: reset, `req`=8'b0001_0100 held, `done` pulsed 2 cycles after each grant:
  - Grant sequence is 8'b0000_0100/idx 2, then 8'b0001_0000/idx 4, then idx 2 again.
  - Exactly one idle cycle separates each grant.
- Wrap-around: with `ptr` at 7 (after serving index 6), `req`=8'b1000_0001 -> idx 7 first, then idx 0 after release.
- Timeout, TIMEOUT=16: `req`=8'b0000_1000 held, `done`=0 -> `grant`=8'b0000_1000 for exactly 16 cycles, then `timeout`=1 for 1 cycle, then idx 3 re-granted one cycle later.
- Done/timeout collision and withdrawal:
  - `done`=1 in the 16th grant cycle -> release with `timeout`=0.
  - Separately, dropping `req[5]` mid-grant -> grant clears at the next edge with no `timeout` pulse.
- Reset mid-grant: `rst` high while idx 6 is granted -> all outputs 0 after that edge; with `req`=8'hFF afterwards, the next grant is idx 0.
